// File: rtl/key_scan_latch16.sv
// key_scan_latch16: synchronises and debounces 16 active-low key contacts on a
// shared divided sample tick, then latches the most recently pressed key and
// presents it as two active-low 8-bit groups for a cascaded 74HC148 pair
// (I1 = keys 15..8, I2 = keys 7..0). Highest index wins on simultaneous presses.
// Optional build macro KEY_AUTO_RELEASE_EN: momentary mode, where the latch
// drops back to idle when the latched key's debounced level returns high.
// Without it the latch is sticky until CLR, reset or a newer press.
module key_scan_latch16 #(
    parameter int DIV    = 50000,
    parameter int STABLE = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] KEY,
    input  logic        CLR,
    output logic [7:0]  I1,
    output logic [7:0]  I2,
    output logic        VALID,
    output logic [15:0] KEY_DB
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(STABLE + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Synchroniser, tick divider and debounced-edge detection state
    logic [15:0]   sync1_q, sync1_d;
    logic [15:0]   sync2_q, sync2_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick;
    logic [15:0]   key_db_w;
    logic [15:0]   db_dly_q, db_dly_d;
    logic [15:0]   press_q, press_d;
`ifdef KEY_AUTO_RELEASE_EN
    logic [15:0]   release_q, release_d;
`endif

    // Latch FSM state and registered outputs
    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   out_n_q, out_n_d;
    logic          valid_q, valid_d;
    logic [3:0]    press_idx;

    assign tick = (div_cnt_q == DW'(DIV - 1));

    // Next values for synchroniser, divider and edge detectors
    always_comb begin
        sync1_d   = KEY;
        sync2_d   = sync1_q;
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
        db_dly_d  = key_db_w;
        // A falling debounced level seen one cycle late gives a registered pulse
        press_d   = db_dly_q & ~key_db_w;
`ifdef KEY_AUTO_RELEASE_EN
        release_d = ~db_dly_q & key_db_w;
`endif
    end

    // Front-end registers; synchronisers and delayed levels idle high
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            div_cnt_q <= '0;
            db_dly_q  <= '1;
            press_q   <= '0;
`ifdef KEY_AUTO_RELEASE_EN
            release_q <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            div_cnt_q <= div_cnt_d;
            db_dly_q  <= db_dly_d;
            press_q   <= press_d;
`ifdef KEY_AUTO_RELEASE_EN
            release_q <= release_d;
`endif
        end
    end

    // Per-key debounce: flip only after STABLE consecutive differing ticks
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_key
            logic          db_q, db_d;
            logic [CW-1:0] cnt_q, cnt_d;

            // Count differing ticks; any agreeing tick restarts the count
            always_comb begin
                db_d  = db_q;
                cnt_d = cnt_q;
                if (tick) begin
                    if (sync2_q[gi] == db_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CW'(STABLE - 1)) begin
                        db_d  = ~db_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            // Debounced level and stability counter registers
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    db_q  <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    db_q  <= db_d;
                    cnt_q <= cnt_d;
                end
            end

            assign key_db_w[gi] = db_q;
        end
    endgenerate

    // Priority pick among simultaneous press pulses: highest index wins
    always_comb begin
        press_idx = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (press_q[k]) begin
                press_idx = 4'(k);
            end
        end
    end

    // Latch FSM next state; outputs are decoded from the next state so they
    // change on the same edge as the state register
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        out_n_d = '1;
        valid_d = 1'b0;
        if (|press_q) begin
            // A press always wins, including over CLR or a release
            state_d = ST_HELD;
            idx_d   = press_idx;
        end else if (state_q == ST_HELD) begin
            if (CLR) begin
                state_d = ST_IDLE;
            end
`ifdef KEY_AUTO_RELEASE_EN
            else if (release_q[idx_q]) begin
                state_d = ST_IDLE;
            end
`endif
        end
        if (state_d == ST_HELD) begin
            out_n_d[idx_d] = 1'b0;
            valid_d        = 1'b1;
        end
    end

    // FSM and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            out_n_q <= '1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_n_q <= out_n_d;
            valid_q <= valid_d;
        end
    end

    assign I1     = out_n_q[15:8];
    assign I2     = out_n_q[7:0];
    assign VALID  = valid_q;
    assign KEY_DB = key_db_w;

endmodule

// File: tb/tb_key_scan_latch16.sv
// Directed testbench for key_scan_latch16 with DIV=4, STABLE=3.
// Each scenario task drives keys, waits (bounded) for debounced edges and
// compares outputs against hand-computed values.
module tb_key_scan_latch16;

    logic        CLK;
    logic        RESET_N;
    logic [15:0] KEY;
    logic        CLR;
    logic [7:0]  I1;
    logic [7:0]  I2;
    logic        VALID;
    logic [15:0] KEY_DB;

    int vectors;
    int miscompares;

    key_scan_latch16 #(.DIV(4), .STABLE(3)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .KEY     (KEY),
        .CLR     (CLR),
        .I1      (I1),
        .I2      (I2),
        .VALID   (VALID),
        .KEY_DB  (KEY_DB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // At most one bit of {I1,I2} may be low in any cycle
    always @(negedge CLK) begin
        vectors++;
        if ($countones(~{I1, I2}) > 1) begin
            miscompares++;
            $display("FAIL invariant_one_hot: {I1,I2}=%h, required at most one zero bit", {I1, I2});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Wait (bounded) for KEY_DB[k] to reach level; reports edges waited
    task automatic wait_db(input int k, input logic level, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 40) begin
            step(1);
            cyc++;
            if (KEY_DB[k] == level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        RESET_N = 1'b0;
        KEY     = '1;
        CLR     = 1'b0;
        step(2);
        vectors += 4;
        if (I1 !== 8'hFF) begin miscompares++; $display("FAIL reset_i1: got %h want ff", I1); end
        if (I2 !== 8'hFF) begin miscompares++; $display("FAIL reset_i2: got %h want ff", I2); end
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", VALID); end
        if (KEY_DB !== 16'hFFFF) begin miscompares++; $display("FAIL reset_keydb: got %h want ffff", KEY_DB); end
        RESET_N = 1'b1;
        step(1);
        // Latch key 5, then reset between clock edges
        KEY[5] = 1'b0;
        wait_db(5, 1'b0, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL reset_k5_timeout: got no KEY_DB[5] fall want fall"); end
        step(2);
        vectors += 2;
        if (I2 !== 8'hDF) begin miscompares++; $display("FAIL reset_k5_latch: got I2=%h want df", I2); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL reset_k5_valid: got %b want 1", VALID); end
        KEY = '1;
        #2 RESET_N = 1'b0;
        #1;
        vectors += 4;
        if (I1 !== 8'hFF) begin miscompares++; $display("FAIL async_reset_i1: got %h want ff", I1); end
        if (I2 !== 8'hFF) begin miscompares++; $display("FAIL async_reset_i2: got %h want ff", I2); end
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid: got %b want 0", VALID); end
        if (KEY_DB !== 16'hFFFF) begin miscompares++; $display("FAIL async_reset_keydb: got %h want ffff", KEY_DB); end
        #3 RESET_N = 1'b1;
        step(20);
        vectors += 3;
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid: got %b want 0", VALID); end
        if ({I1, I2} !== 16'hFFFF) begin miscompares++; $display("FAIL post_reset_out: got %h want ffff", {I1, I2}); end
        if (KEY_DB !== 16'hFFFF) begin miscompares++; $display("FAIL post_reset_keydb: got %h want ffff", KEY_DB); end
        $display("test_reset: key5 latched, async reset cleared outputs, no event after release");
    endtask

    task automatic test_clean_press_12();
        int cyc;
        bit ok;
        KEY[12] = 1'b0;
        wait_db(12, 1'b0, cyc, ok);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL k12_timeout: got no KEY_DB[12] fall want fall"); end
        if (cyc < 10 || cyc > 14) begin miscompares++; $display("FAIL k12_db_latency: got %0d cycles want 10..14", cyc); end
        step(1);
        vectors++;
        if (VALID !== 1'b0 || I1 !== 8'hFF) begin
            miscompares++; $display("FAIL k12_early: got VALID=%b I1=%h want 0 ff one cycle after flip", VALID, I1);
        end
        step(1);
        vectors += 3;
        if (I1 !== 8'hEF) begin miscompares++; $display("FAIL k12_i1: got %h want ef", I1); end
        if (I2 !== 8'hFF) begin miscompares++; $display("FAIL k12_i2: got %h want ff", I2); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL k12_valid: got %b want 1", VALID); end
        KEY[12] = 1'b1;
        wait_db(12, 1'b1, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k12_release_timeout: got no KEY_DB[12] rise want rise"); end
        step(2);
        vectors += 2;
`ifdef KEY_AUTO_RELEASE_EN
        if (I1 !== 8'hFF) begin miscompares++; $display("FAIL k12_after_release_i1: got %h want ff", I1); end
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL k12_after_release_valid: got %b want 0", VALID); end
`else
        if (I1 !== 8'hEF) begin miscompares++; $display("FAIL k12_sticky_i1: got %h want ef", I1); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL k12_sticky_valid: got %b want 1", VALID); end
`endif
        $display("test_clean_press_12: flip after %0d cycles, I1=%h VALID=%b after release", cyc, I1, VALID);
    endtask

    task automatic test_clear();
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        vectors += 2;
        if ({I1, I2} !== 16'hFFFF) begin miscompares++; $display("FAIL clr_out: got %h want ffff", {I1, I2}); end
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL clr_valid: got %b want 0", VALID); end
        $display("test_clear: outputs %h VALID=%b", {I1, I2}, VALID);
    endtask

    task automatic test_bounce();
        int cyc;
        bit ok;
        // Low for exactly two tick periods: the sample is 0 on exactly two ticks
        KEY[3] = 1'b0;
        step(8);
        KEY[3] = 1'b1;
        step(12);
        vectors += 2;
        if (KEY_DB !== 16'hFFFF) begin miscompares++; $display("FAIL bounce_keydb: got %h want ffff", KEY_DB); end
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL bounce_valid: got %b want 0", VALID); end
        KEY[3] = 1'b0;
        wait_db(3, 1'b0, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k3_timeout: got no KEY_DB[3] fall want fall"); end
        step(2);
        vectors += 3;
        if (I2 !== 8'hF7) begin miscompares++; $display("FAIL k3_i2: got %h want f7", I2); end
        if (I1 !== 8'hFF) begin miscompares++; $display("FAIL k3_i1: got %h want ff", I1); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL k3_valid: got %b want 1", VALID); end
        KEY[3] = 1'b1;
        wait_db(3, 1'b1, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k3_release_timeout: got no KEY_DB[3] rise want rise"); end
        step(2);
        $display("test_bounce: glitch rejected, held press gave I2=f7");
    endtask

    task automatic test_simultaneous();
        int cyc;
        bit ok;
        KEY[2] = 1'b0;
        KEY[9] = 1'b0;
        wait_db(9, 1'b0, cyc, ok);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL k2k9_timeout: got no KEY_DB[9] fall want fall"); end
        if (KEY_DB !== 16'hFDFB) begin miscompares++; $display("FAIL k2k9_keydb: got %h want fdfb", KEY_DB); end
        step(2);
        vectors += 3;
        if (I1 !== 8'hFD) begin miscompares++; $display("FAIL k2k9_i1: got %h want fd", I1); end
        if (I2 !== 8'hFF) begin miscompares++; $display("FAIL k2k9_i2: got %h want ff", I2); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL k2k9_valid: got %b want 1", VALID); end
        // Overwrite with key 0 while 2 and 9 are still held
        KEY[0] = 1'b0;
        wait_db(0, 1'b0, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k0_timeout: got no KEY_DB[0] fall want fall"); end
        step(2);
        vectors += 3;
        if (I2 !== 8'hFE) begin miscompares++; $display("FAIL k0_i2: got %h want fe", I2); end
        if (I1 !== 8'hFF) begin miscompares++; $display("FAIL k0_i1: got %h want ff", I1); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL k0_valid: got %b want 1", VALID); end
        KEY = '1;
        wait_db(9, 1'b1, cyc, ok);
        wait_db(0, 1'b1, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k0_release_timeout: got no KEY_DB[0] rise want rise"); end
        step(2);
        $display("test_simultaneous: key9 won over key2, key0 overwrote");
    endtask

    task automatic test_clr_collision();
        int cyc;
        bit ok;
        KEY[7] = 1'b0;
        wait_db(7, 1'b0, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k7_timeout: got no KEY_DB[7] fall want fall"); end
        step(1);
        // Press pulse for key 7 is high now; CLR is sampled together with it
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        vectors += 3;
        if (I2 !== 8'h7F) begin miscompares++; $display("FAIL clr_collide_i2: got %h want 7f", I2); end
        if (I1 !== 8'hFF) begin miscompares++; $display("FAIL clr_collide_i1: got %h want ff", I1); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL clr_collide_valid: got %b want 1", VALID); end
        step(3);
        vectors++;
        if (I2 !== 8'h7F) begin miscompares++; $display("FAIL k7_hold_i2: got %h want 7f", I2); end
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        vectors += 2;
        if ({I1, I2} !== 16'hFFFF) begin miscompares++; $display("FAIL clr_alone_out: got %h want ffff", {I1, I2}); end
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL clr_alone_valid: got %b want 0", VALID); end
        KEY[7] = 1'b1;
        wait_db(7, 1'b1, cyc, ok);
        step(2);
        vectors++;
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL k7_release_valid: got %b want 0", VALID); end
        $display("test_clr_collision: press beat CLR, CLR alone cleared");
    endtask

`ifdef KEY_AUTO_RELEASE_EN
    task automatic test_auto_release();
        int cyc;
        bit ok;
        KEY[15] = 1'b0;
        wait_db(15, 1'b0, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k15_timeout: got no KEY_DB[15] fall want fall"); end
        step(2);
        vectors += 2;
        if (I1 !== 8'h7F) begin miscompares++; $display("FAIL k15_i1: got %h want 7f", I1); end
        if (VALID !== 1'b1) begin miscompares++; $display("FAIL k15_valid: got %b want 1", VALID); end
        KEY[15] = 1'b1;
        wait_db(15, 1'b1, cyc, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k15_release_timeout: got no KEY_DB[15] rise want rise"); end
        step(1);
        vectors++;
        if (VALID !== 1'b1 || I1 !== 8'h7F) begin
            miscompares++; $display("FAIL k15_early_release: got VALID=%b I1=%h want 1 7f", VALID, I1);
        end
        step(1);
        vectors += 2;
        if ({I1, I2} !== 16'hFFFF) begin miscompares++; $display("FAIL k15_release_out: got %h want ffff", {I1, I2}); end
        if (VALID !== 1'b0) begin miscompares++; $display("FAIL k15_release_valid: got %b want 0", VALID); end
        $display("test_auto_release: key15 released to idle two cycles after debounce");
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_clean_press_12();
        test_clear();
        test_bounce();
        test_simultaneous();
        test_clr_collision();
`ifdef KEY_AUTO_RELEASE_EN
        test_auto_release();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
